// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory responder: req/ack handshake, store lane steering,
// load extraction/extension, pipeline stall and bus timeout.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memread_ex_mem,
  input  logic        memwrite_ex_mem,
  input  logic [31:0] addr_ex_mem,
  input  logic [31:0] wdata_ex_mem,
  input  logic [1:0]  size_ex_mem,
  input  logic        unsigned_ex_mem,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata_out,
  output logic        stall_mem,
  output logic        misalign,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       size_q;
  logic [1:0]       off_q;
  logic             uns_q;
  logic             flush_seen;

  logic             acc_v;
  logic             acc_ok;
  logic             start;
  logic             timeout_hit;
  logic [3:0]       be_n;
  logic [31:0]      wdata_n;
  logic [7:0]       lane8;
  logic [15:0]      lane16;
  logic [31:0]      load_fmt;

  assign acc_v = memread_ex_mem ^ memwrite_ex_mem;

  always_comb begin
    acc_ok = 1'b0;
    case (size_ex_mem)
      2'b00:   acc_ok = 1'b1;
      2'b01:   acc_ok = ~addr_ex_mem[0];
      2'b10:   acc_ok = (addr_ex_mem[1:0] == 2'b00);
      default: acc_ok = 1'b0;
    endcase
  end

  assign start     = (state == IDLE) && acc_v && acc_ok && !flush;
  assign stall_mem = rst_n && (start || (state == BUSY));
  assign misalign  = rst_n && (state == IDLE) && !flush &&
                     ((acc_v && !acc_ok) || (memread_ex_mem && memwrite_ex_mem));

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == TO_LAST);

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = wdata_ex_mem;
    case (size_ex_mem)
      2'b00: begin
        be_n    = 4'b0001 << addr_ex_mem[1:0];
        wdata_n = {4{wdata_ex_mem[7:0]}};
      end
      2'b01: begin
        be_n    = addr_ex_mem[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{wdata_ex_mem[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = wdata_ex_mem;
      end
    endcase
    if (!memwrite_ex_mem) wdata_n = '0;
  end

  always_comb begin
    lane8    = mem_rdata[{off_q, 3'b000} +: 8];
    lane16   = mem_rdata[{off_q[1], 4'b0000} +: 16];
    load_fmt = mem_rdata;
    case (size_q)
      2'b00:   load_fmt = {{24{~uns_q & lane8[7]}}, lane8};
      2'b01:   load_fmt = {{16{~uns_q & lane16[15]}}, lane16};
      default: load_fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      size_q      <= '0;
      off_q       <= '0;
      uns_q       <= 1'b0;
      flush_seen  <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      rdata_out   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= BUSY;
            mem_req    <= 1'b1;
            mem_we     <= memwrite_ex_mem;
            mem_addr   <= addr_ex_mem[31:2];
            mem_be     <= be_n;
            mem_wdata  <= wdata_n;
            size_q     <= size_ex_mem;
            uns_q      <= unsigned_ex_mem;
            off_q      <= addr_ex_mem[1:0];
            cnt        <= '0;
            flush_seen <= 1'b0;
          end
        end
        BUSY: begin
          if (flush) flush_seen <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DONE;
            // a flush arriving in the ack cycle also discards the load result
            if (!mem_we && !flush_seen && !flush) rdata_out <= load_fmt;
          end else if (timeout_hit) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            state       <= DONE;
            if (!mem_we) rdata_out <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          flush_seen <= 1'b0;
          cnt        <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: vector table, directed corner sequences and
// randomized transactions against a transaction-level reference model.
module tb_dmem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memread_ex_mem, memwrite_ex_mem;
  logic [31:0] addr_ex_mem, wdata_ex_mem;
  logic [1:0]  size_ex_mem;
  logic        unsigned_ex_mem, flush;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata, rdata_out;
  logic        stall_mem, misalign, timeout_err;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .memread_ex_mem(memread_ex_mem), .memwrite_ex_mem(memwrite_ex_mem),
    .addr_ex_mem(addr_ex_mem), .wdata_ex_mem(wdata_ex_mem),
    .size_ex_mem(size_ex_mem), .unsigned_ex_mem(unsigned_ex_mem),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rdata_out(rdata_out), .stall_mem(stall_mem),
    .misalign(misalign), .timeout_err(timeout_err)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_rdata;

  logic        obs_mis, obs_stall, obs_req, obs_we;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  int          obs_nstall, obs_nto;

  typedef struct {
    logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata;
    logic [1:0] size; logic uns; logic fl;
    logic mis; logic stall; logic we; logic [3:0] be; logic [31:0] wd;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [31:0] r, input int off,
                                      input logic [1:0] sz, input logic uns);
    longint v;
    if (sz == 2'b10) return r;
    if (sz == 2'b00) begin
      v = (r >> (8 * off)) & 32'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else begin
      v = (r >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    memread_ex_mem = 1'b0; memwrite_ex_mem = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    addr_ex_mem = $urandom; wdata_ex_mem = $urandom;
    size_ex_mem = 2'($urandom_range(0, 3)); unsigned_ex_mem = 1'($urandom_range(0, 1));
  endtask

  // One access presented in IDLE; ack in window cycle k, flush in window cycle f (0 = none).
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                        input logic fl, input int k, input int f, input logic [31:0] rdv);
    logic valid, aligned, req, mis, stable;
    int off, nbusy, n_st, n_rq, n_to;
    logic [3:0] e_be;
    logic [31:0] e_wd;
    valid   = rd ^ wr;
    off     = int'(addr[1:0]);
    aligned = (sz == 2'b00) || (sz == 2'b01 && addr[0] == 1'b0) || (sz == 2'b10 && off == 0);
    req     = valid && aligned && !fl;
    mis     = !fl && ((valid && !aligned) || (rd && wr));
    nbusy   = (k < TO) ? k : TO;
    e_be    = (sz == 2'b00) ? 4'(1 << off) : (sz == 2'b01) ? ((off >= 2) ? 4'hC : 4'h3) : 4'hF;
    e_wd    = !wr ? 32'h0 :
              (sz == 2'b00) ? (wd & 32'hFF) * 32'h01010101 :
              (sz == 2'b01) ? (wd & 32'hFFFF) * 32'h00010001 : wd;

    memread_ex_mem = rd; memwrite_ex_mem = wr; addr_ex_mem = addr; wdata_ex_mem = wd;
    size_ex_mem = sz; unsigned_ex_mem = uns; flush = fl; mem_ack = 1'b0;
    #1;
    obs_mis = misalign; obs_stall = stall_mem;
    chk("misalign", {31'b0, misalign}, {31'b0, mis});
    chk("stall_issue", {31'b0, stall_mem}, {31'b0, req});
    @(posedge clk); @(negedge clk);
    idle_inputs();
    obs_req = mem_req; obs_we = mem_we; obs_be = mem_be; obs_wdata = mem_wdata;
    chk("mem_req_issue", {31'b0, mem_req}, {31'b0, req});
    if (req) begin
      chk("mem_we", {31'b0, mem_we}, {31'b0, wr});
      chk("mem_addr", {2'b0, mem_addr}, addr >> 2);
      chk("mem_be", {28'b0, mem_be}, {28'b0, e_be});
      chk("mem_wdata", mem_wdata, e_wd);
    end
    n_st = 0; n_rq = 0; n_to = 0; stable = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      mem_ack = (i == k); flush = (i == f);
      mem_rdata = (i == k) ? rdv : $urandom;
      #1;
      if (stall_mem) n_st++;
      if (mem_req) n_rq++;
      if (timeout_err) n_to++;
      if (mem_req && (mem_addr !== addr[31:2] || mem_be !== e_be ||
                      mem_wdata !== e_wd || mem_we !== wr)) stable = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    mem_ack = 1'b0; flush = 1'b0;
    if (req && rd) begin
      if (k > TO) exp_rdata = 32'h0;
      else if (!(f >= 1 && f <= k)) exp_rdata = fmt(rdv, off, sz, uns);
    end
    chk("stall_busy_cycles", n_st, req ? nbusy : 0);
    chk("req_cycles", n_rq, req ? nbusy : 0);
    chk("timeout_pulses", n_to, (req && k > TO) ? 1 : 0);
    if (req) chk("bus_hold", {31'b0, stable}, 32'h1);
    chk("rdata_out", rdata_out, exp_rdata);
    chk("idle_stall", {31'b0, stall_mem}, 32'h0);
    obs_nstall = n_st + (obs_stall ? 1 : 0);
    obs_nto = n_to;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h103, 32'h000000A5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h8, 32'hA5A5A5A5};
    tbl[2]  = '{1'b0, 1'b1, 32'h202, 32'h0000ABCD, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hC, 32'hABCDABCD};
    tbl[3]  = '{1'b1, 1'b0, 32'h200, 32'hFFFFFFFF, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h101, 32'h0,        2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 32'h201, 32'h1234,     2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,   32'h0,        2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 32'h100, 32'h0,        2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h101, 32'h0,        2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,   32'h0,        2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 32'h101, 32'h12345677, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 32'h77777777};
    tbl[12] = '{1'b0, 1'b1, 32'h104, 32'h87654321, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h87654321};

    // reset, with an illegal access presented to show misalign/stall gated
    rst_n = 1'b0; idle_inputs(); mem_rdata = '0;
    memread_ex_mem = 1'b1; memwrite_ex_mem = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_addr", {2'b0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
    chk("rst_rdata_out", rdata_out, 32'h0);
    chk("rst_timeout_err", {31'b0, timeout_err}, 32'h0);
    chk("rst_stall", {31'b0, stall_mem}, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    exp_rdata = 32'h0;
    idle_inputs(); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    foreach (tbl[i]) begin
      do_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].size, tbl[i].uns,
             tbl[i].fl, 1, 0, $urandom);
      chk("tbl_misalign", {31'b0, obs_mis}, {31'b0, tbl[i].mis});
      chk("tbl_stall", {31'b0, obs_stall}, {31'b0, tbl[i].stall});
      chk("tbl_req", {31'b0, obs_req}, {31'b0, tbl[i].stall});
      if (tbl[i].stall) begin
        chk("tbl_we", {31'b0, obs_we}, {31'b0, tbl[i].we});
        chk("tbl_be", {28'b0, obs_be}, {28'b0, tbl[i].be});
        chk("tbl_wdata", obs_wdata, tbl[i].wd);
      end
    end

    // word load, ack two cycles after mem_req rises
    do_txn(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 1'b0, 3, 0, 32'hDEADBEEF);
    chk("wl_rdata", rdata_out, 32'hDEADBEEF);
    chk("wl_stall_cycles", obs_nstall, 4);
    // signed / unsigned byte load from the top lane
    do_txn(1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 1'b0, 2, 0, 32'h80FF1234);
    chk("sb_rdata", rdata_out, 32'hFFFFFF80);
    do_txn(1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 1'b0, 1, 0, 32'h80FF1234);
    chk("ub_rdata", rdata_out, 32'h00000080);
    // half store leaves rdata_out alone
    do_txn(1'b0, 1'b1, 32'h202, 32'h0000ABCD, 2'b01, 1'b0, 1'b0, 2, 0, 32'h55555555);
    chk("hs_we", {31'b0, obs_we}, 32'h1);
    chk("hs_wdata", obs_wdata, 32'hABCDABCD);
    chk("hs_rdata", rdata_out, 32'h00000080);
    // flush in the 2nd BUSY cycle discards the load result
    do_txn(1'b1, 1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 1'b0, 3, 2, 32'h12345678);
    chk("fl_rdata", rdata_out, 32'h00000080);
    chk("fl_stall_cycles", obs_nstall, 4);
    // timeout: late ack in IDLE, then late ack in DONE
    do_txn(1'b1, 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 1'b0, 6, 0, 32'hCAFEF00D);
    chk("to_rdata", rdata_out, 32'h0);
    chk("to_pulse", obs_nto, 1);
    do_txn(1'b1, 1'b0, 32'h404, 32'h0, 2'b10, 1'b0, 1'b0, 1, 0, 32'h0BADCAFE);
    do_txn(1'b1, 1'b0, 32'h408, 32'h0, 2'b10, 1'b0, 1'b0, 5, 0, 32'h11112222);
    chk("to2_rdata", rdata_out, 32'h0);

    // reset mid-BUSY abandons the request
    memread_ex_mem = 1'b1; addr_ex_mem = 32'h500; size_ex_mem = 2'b10;
    @(posedge clk); @(negedge clk);
    idle_inputs();
    chk("midrst_req_before", {31'b0, mem_req}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst_req", {31'b0, mem_req}, 32'h0);
    chk("midrst_stall", {31'b0, stall_mem}, 32'h0);
    exp_rdata = 32'h0;
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      logic [1:0] rw;
      int kk, ff;
      rw = 2'($urandom_range(0, 3));
      kk = $urandom_range(1, 6);
      ff = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
      do_txn(rw[0], rw[1], $urandom, $urandom, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), kk, ff, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
